// File: rtl/cic_interpolator.sv
`timescale 1ns/1ps
// cic_interpolator
// Transmit-side CIC interpolator: comb -> zero-stuff upsampler -> integrator.
// Low-rate samples enter through a one-deep holding register on an en/din
// strobe and come out RATE times faster on valid/dout. The output cadence is
// set by an internal clock-enable divider running on the system clock.
module cic_interpolator #(
    parameter int NIN          = 16,
    parameter int NOUT         = 16,
    parameter int NMAX         = 40,
    parameter int ORDER        = 3,
    parameter int RATE         = 8,
    parameter int SYS_CLK_FREQ = 6_400_000,
    parameter int OUT_RATE     = 6_400
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic signed [NIN-1:0]  din,
    output logic                   ready,
    output logic                   valid,
    output logic signed [NOUT-1:0] dout,
    output logic                   underrun,
    output logic                   overrun
);

    localparam int CLKS_PER_OUT = SYS_CLK_FREQ / OUT_RATE;
    localparam int CNT_W        = (CLKS_PER_OUT > 1) ? $clog2(CLKS_PER_OUT) : 1;
    localparam int PH_W         = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int GAIN_SHIFT   = (ORDER - 1) * PH_W;

    // Output-rate divider and interpolation phase
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             tick;
    logic             tick0;

    // Input holding register and sticky status flags
    logic signed [NIN-1:0] hold_q, hold_d;
    logic                  full_q, full_d;
    logic                  underrun_q, underrun_d;
    logic                  overrun_q, overrun_d;
    logic signed [NIN-1:0] combIn;

    // Comb delays, combinational comb taps and the upsampled comb output
    logic signed [NMAX-1:0] combZ_q [ORDER];
    logic signed [NMAX-1:0] combTap [ORDER];
    logic signed [NMAX-1:0] combOut;
    logic signed [NMAX-1:0] upSample;

    // Pipelined integrator chain and registered output
    logic signed [NMAX-1:0] integ_q [ORDER];
    logic signed [NMAX-1:0] integ_d [ORDER];
    logic signed [NOUT-1:0] dout_q, dout_d;
    logic                   valid_q;

    // Divider wraps at CLKS_PER_OUT-1; each tick steps the phase, and phase 0 pulls a new input
    always_comb begin
        tick    = (cnt_q == CNT_W'(CLKS_PER_OUT - 1));
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        tick0   = tick && (phase_q == '0);
        phase_d = phase_q;
        if (tick) begin
            phase_d = (phase_q == PH_W'(RATE - 1)) ? '0 : phase_q + PH_W'(1);
        end
    end

    // Holding register: choose what feeds the comb on a phase-0 tick and track full/overrun/underrun
    always_comb begin
        hold_d     = hold_q;
        full_d     = full_q;
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        combIn     = '0;
        if (tick0) begin
            if (full_q) begin
                // Stored sample leaves; a coincident strobe refills the register at once
                combIn = hold_q;
                if (en) begin
                    hold_d = din;
                    full_d = 1'b1;
                end else begin
                    full_d = 1'b0;
                end
            end else if (en) begin
                // Empty register and a coincident strobe: the new sample goes straight in
                combIn = din;
            end else begin
                underrun_d = 1'b1;
            end
        end else if (en) begin
            if (full_q) begin
                overrun_d = 1'b1;
            end else begin
                hold_d = din;
                full_d = 1'b1;
            end
        end
    end

    // Comb chain: sign-extend the input, then each stage subtracts its own delayed input
    always_comb begin
        logic signed [NMAX-1:0] acc;
        acc = NMAX'(combIn);
        for (int k = 0; k < ORDER; k++) begin
            combTap[k] = acc;
            acc        = acc - combZ_q[k];
        end
        combOut  = acc;
        upSample = tick0 ? combOut : '0;
    end

    // Integrators add the previous stage's old value, so each stage is one tick behind the last
    always_comb begin
        integ_d[0] = integ_q[0] + upSample;
        for (int k = 1; k < ORDER; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        dout_d = NOUT'(integ_d[ORDER-1] >>> GAIN_SHIFT);
    end

    // Divider, phase counter, holding register and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            phase_q    <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    // Comb delay registers only move when a new low-rate sample enters the chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                combZ_q[k] <= '0;
            end
        end else if (tick0) begin
            for (int k = 0; k < ORDER; k++) begin
                combZ_q[k] <= combTap[k];
            end
        end
    end

    // Integrators run once per output tick; sums wrap modulo 2^NMAX by design
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
        end else if (tick) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
            end
        end
    end

    // Output register: one-cycle valid after every tick, dout held until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            valid_q <= tick;
            if (tick) begin
                dout_q <= dout_d;
            end
        end
    end

    assign ready    = !full_q;
    assign valid    = valid_q;
    assign dout     = dout_q;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
`timescale 1ns/1ps
// tb_cic_interpolator
// Directed bench for cic_interpolator with CLKS_PER_OUT=8, ORDER=3, RATE=8.
// The reference is a direct convolution of the input samples with the
// box(8)*box(8)*box(8) kernel placed on the phase-0 ticks, scaled by 2^-6.
module tb_cic_interpolator;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [15:0] din;
    logic               ready;
    logic               valid;
    logic signed [15:0] dout;
    logic               underrun;
    logic               overrun;

    int checks = 0;
    int errors = 0;

    int                 k3 [22];
    int                 xs [256];
    int                 mIdx = 0;
    logic signed [15:0] expQ [$];
    int                 outLog [1024];
    int                 outCount = 0;
    int                 cyc = 0;
    int                 lastValid = 0;
    bit                 havePrev = 1'b0;

    cic_interpolator #(
        .NIN(16), .NOUT(16), .NMAX(40), .ORDER(3), .RATE(8),
        .SYS_CLK_FREQ(64), .OUT_RATE(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .ready(ready), .valid(valid), .dout(dout),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for the valid cadence check
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: push the eight outputs whose last contributing input is this sample
    task automatic pushExpect(input int v);
        longint acc;
        longint shifted;
        int n;
        int k;
        xs[mIdx] = v;
        for (int p = 0; p < 8; p++) begin
            n   = 8 * mIdx + p;
            acc = 0;
            for (int j = 0; j <= mIdx; j++) begin
                k = n - 2 - 8 * j;
                if (k >= 0 && k < 22) acc += longint'(xs[j]) * longint'(k3[k]);
            end
            shifted = acc >>> 6;
            expQ.push_back(shifted[15:0]);
        end
        mIdx++;
    endtask

    // Wait for the holding register to empty, then strobe one sample in
    task automatic applyStimulus(input int v);
        int w = 0;
        while (ready !== 1'b1 && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput("readyWait", ready, 1);
        pushExpect(v);
        en  = 1'b1;
        din = 16'(v);
        @(posedge clk); #1;
        en  = 1'b0;
    endtask

    task automatic waitOutputs(input int n);
        int w = 0;
        while (outCount < n && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput("outputWait", (outCount >= n) ? 1 : 0, 1);
    endtask

    task automatic checkResetState();
        checkOutput("rstReady", ready, 1);
        checkOutput("rstValid", valid, 0);
        checkOutput("rstDout", dout, 0);
        checkOutput("rstUnderrun", underrun, 0);
        checkOutput("rstOverrun", overrun, 0);
    endtask

    task automatic clearModel();
        expQ.delete();
        for (int i = 0; i < 256; i++) xs[i] = 0;
        mIdx     = 0;
        outCount = 0;
        havePrev = 1'b0;
    endtask

    // Scoreboard side: every valid pops one expected sample and checks the cadence
    always @(negedge clk) begin
        if (rst === 1'b0 && valid === 1'b1) begin
            if (havePrev) checkOutput("validPeriod", cyc - lastValid, 8);
            havePrev  = 1'b1;
            lastValid = cyc;
            if (outCount < 1024) outLog[outCount] = dout;
            if (expQ.size() > 0) checkOutput("dout", dout, expQ.pop_front());
            outCount++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int box2 [15];
        int mImp;
        int sum;
        int nz;
        int firstAt;

        for (int i = 0; i < 15; i++) box2[i] = 0;
        for (int i = 0; i < 22; i++) k3[i] = 0;
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++) box2[a+b]++;
        for (int c = 0; c < 15; c++)
            for (int d = 0; d < 8; d++) k3[c+d] += box2[c];
        clearModel();

        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        repeat (5) @(posedge clk);
        #1;
        checkResetState();
        rst = 1'b0;

        // Positive DC settles to the input value
        for (int i = 0; i < 6; i++) applyStimulus(1000);
        waitOutputs(41);
        checkOutput("dcSteady", outLog[40], 1000);

        // Negative DC, long run
        for (int i = 0; i < 40; i++) applyStimulus(-2000);
        waitOutputs(351);
        checkOutput("negDcSteady", outLog[350], -2000);

        // Isolated impulse
        for (int i = 0; i < 3; i++) applyStimulus(0);
        mImp = mIdx;
        applyStimulus(64);
        for (int i = 0; i < 4; i++) applyStimulus(0);

        // Overrun: second strobe while the register is still full
        checkOutput("overrunClear", overrun, 0);
        applyStimulus(5);
        en  = 1'b1;
        din = 16'sd777;
        @(posedge clk); #1;
        en  = 1'b0;
        checkOutput("overrunSet", overrun, 1);
        checkOutput("overrunReady", ready, 0);
        applyStimulus(-7);

        waitOutputs(8 * mImp + 32);
        sum = 0;
        nz  = 0;
        for (int n = 8 * mImp; n < 8 * mImp + 32; n++) begin
            sum += outLog[n];
            if (outLog[n] != 0) nz++;
        end
        checkOutput("impulseSum", sum, 512);
        checkOutput("impulseTaps", nz, 22);

        // Underrun: skip one input period
        checkOutput("underrunClear", underrun, 0);
        pushExpect(0);
        waitOutputs(8 * (mIdx - 1) + 1);
        checkOutput("underrunSet", underrun, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1234);
        checkOutput("underrunSticky", underrun, 1);

        // Reset in the middle of the stream
        rst = 1'b1;
        clearModel();
        repeat (5) @(posedge clk);
        #1;
        checkResetState();
        rst = 1'b0;
        pushExpect(300);
        en  = 1'b1;
        din = 16'sd300;
        firstAt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) en = 1'b0;
            if (valid === 1'b1 && firstAt == 0) firstAt = i;
        end
        checkOutput("firstValidDelay", firstAt, 8);
        for (int i = 0; i < 3; i++) applyStimulus(300);
        waitOutputs(8 * mIdx);
        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
